// File: rtl/dsp_mul_arb_pkg.sv
// Shared types and helpers for the DSP multiplier arbiter.
// Imported by the interface-level users, the round-robin sub-module and the top.
package dsp_mul_arb_pkg;

  localparam int STAT_BITS   = 32;
  localparam int ID_BITS_MAX = 4;

  typedef logic [ID_BITS_MAX-1:0] id_t;

  // Control side of one pipeline stage; the id rides alongside the operands.
  typedef struct packed {
    logic valid;
    id_t  id;
  } pipe_tag_t;

  function automatic int id_bits(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/dsp_mul_arbiter_if.sv
// Requester and tagged-result bus of the DSP multiplier arbiter.
// master = client side (drives requests, consumes results), slave = arbiter side.
interface dsp_mul_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int A_BITS  = 27,
  parameter int B_BITS  = 18,
  parameter int P_BITS  = 45,
  parameter int ID_BITS = 2
);

  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ-1:0]        s_ready;
  logic [N_REQ*A_BITS-1:0] s_a;
  logic [N_REQ*B_BITS-1:0] s_b;
  logic                    m_valid;
  logic                    m_ready;
  logic [ID_BITS-1:0]      m_id;
  logic [P_BITS-1:0]       m_p;

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_id, m_p
  );

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_id, m_p
  );

endinterface

// File: rtl/dsp_mul_arb_rr.sv
// Combinational round-robin grant: search starts at ptr and wraps; the winner's
// successor becomes the next pointer when the grant is actually taken.
module dsp_mul_arb_rr
  import dsp_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  id_t              ptr,
  input  logic             take,
  output logic [N_REQ-1:0] grant,
  output id_t              grant_id,
  output id_t              ptr_next
);

  logic [N_REQ-1:0] req_rot;
  id_t              offset;
  logic             found;

  // Rotating the request vector by ptr turns the wrap-around search into a
  // plain lowest-set-bit search.
  always_comb begin
    req_rot = N_REQ'({req, req} >> ptr);
    offset  = '0;
    found   = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        offset = id_t'(j);
        found  = 1'b1;
      end
    end

    grant_id = id_t'((int'(ptr) + int'(offset)) % N_REQ);

    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = found && (grant_id == id_t'(i));
    end

    ptr_next = take ? id_t'((int'(grant_id) + 1) % N_REQ) : ptr;
  end

endmodule

// File: rtl/dsp_mul_arbiter.sv
// Shares one pipelined signed multiplier between N_REQ requesters with a tagged result stream.
// Optional per-requester accept counters are built when DSP_MUL_ARB_STAT_EN is defined.
module dsp_mul_arbiter
  import dsp_mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 6,
  parameter int A_BITS  = 27,
  parameter int B_BITS  = 18,
  parameter int P_BITS  = 45,
  parameter int SHIFT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  dsp_mul_arbiter_if.slave bus
`ifdef DSP_MUL_ARB_STAT_EN
  ,
  input  logic                       stat_clr,
  output logic [N_REQ*STAT_BITS-1:0] stat_cnt
`endif
);

  localparam int ID_BITS   = id_bits(N_REQ);
  localparam int NP        = LATENCY - 1;
  localparam int FULL_BITS = A_BITS + B_BITS;
  localparam int EXT_BITS  = (FULL_BITS > P_BITS) ? FULL_BITS : P_BITS;

  logic             advance;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] xfer;
  logic             xfer_any;
  id_t              grant_id;
  id_t              ptr_q, ptr_d;

  logic signed [A_BITS-1:0]    a_q, a_d;
  logic signed [B_BITS-1:0]    b_q, b_d;
  logic signed [FULL_BITS-1:0] m_q, m_d;
  logic signed [EXT_BITS-1:0]  m_ext;

  pipe_tag_t         ab_tag_q, ab_tag_d;
  pipe_tag_t         m_tag_q, m_tag_d;
  pipe_tag_t         p_tag_q [NP];
  pipe_tag_t         p_tag_d [NP];
  logic [P_BITS-1:0] p_q [NP];
  logic [P_BITS-1:0] p_d [NP];

  // A held output freezes the whole pipe, so nothing can be accepted behind it.
  assign advance     = cke & ~(bus.m_valid & ~bus.m_ready);
  assign bus.s_ready = grant & {N_REQ{advance & ~reset}};
  assign xfer        = bus.s_valid & bus.s_ready;
  assign xfer_any    = |xfer;

  dsp_mul_arb_rr #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req      (bus.s_valid),
    .ptr      (ptr_q),
    .take     (xfer_any),
    .grant    (grant),
    .grant_id (grant_id),
    .ptr_next (ptr_d)
  );

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_d = bus.s_a[i*A_BITS +: A_BITS];
        b_d = bus.s_b[i*B_BITS +: B_BITS];
      end
    end
    ab_tag_d = '{valid: xfer_any, id: grant_id};

    m_d     = a_q * b_q;
    m_tag_d = ab_tag_q;

    // Sign-extend before shifting so the arithmetic shift sees the true sign.
    m_ext      = m_q;
    p_d[0]     = P_BITS'(m_ext >>> SHIFT);
    p_tag_d[0] = m_tag_q;
    for (int s = 1; s < NP; s++) begin
      p_d[s]     = p_q[s-1];
      p_tag_d[s] = p_tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      ab_tag_q <= '0;
      m_tag_q  <= '0;
      for (int s = 0; s < NP; s++) begin
        p_tag_q[s] <= '0;
        p_q[s]     <= '0;
      end
    end else if (advance) begin
      ptr_q    <= ptr_d;
      ab_tag_q <= ab_tag_d;
      m_tag_q  <= m_tag_d;
      for (int s = 0; s < NP; s++) begin
        p_tag_q[s] <= p_tag_d[s];
        p_q[s]     <= p_d[s];
      end
    end
  end

  // Operand and product registers carry no reset so they map onto the DSP A/B/M registers.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
    end
  end

  assign bus.m_valid = p_tag_q[NP-1].valid;
  assign bus.m_id    = p_tag_q[NP-1].id[ID_BITS-1:0];
  assign bus.m_p     = p_q[NP-1];

`ifdef DSP_MUL_ARB_STAT_EN
  logic [STAT_BITS-1:0] stat_q [N_REQ];
  logic [STAT_BITS-1:0] stat_d [N_REQ];

  // Clear takes priority over a same-cycle accept.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_d[i] = stat_clr ? '0 : stat_q[i] + STAT_BITS'(xfer[i]);
      stat_cnt[i*STAT_BITS +: STAT_BITS] = stat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else if (cke) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Scoreboard bench for dsp_mul_arbiter: a behavioural arbiter/pipe model predicts
// grants and pushes expected results; monitors pop and compare on every presented result.
module tb_dsp_mul_arbiter;
  import dsp_mul_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int LATENCY = 6;
  localparam int A_BITS  = 27;
  localparam int B_BITS  = 18;
  localparam int P_BITS  = 45;
  localparam int ID_BITS = id_bits(N_REQ);

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic [P_BITS-1:0]  p;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic cke;
  always #5 clk = ~clk;

  dsp_mul_arbiter_if #(.N_REQ(N_REQ), .A_BITS(A_BITS), .B_BITS(B_BITS),
                       .P_BITS(P_BITS), .ID_BITS(ID_BITS)) bus ();
  dsp_mul_arbiter_if #(.N_REQ(N_REQ), .A_BITS(A_BITS), .B_BITS(B_BITS),
                       .P_BITS(P_BITS), .ID_BITS(ID_BITS)) bus_sh ();

`ifdef DSP_MUL_ARB_STAT_EN
  logic                       stat_clr;
  logic                       stat_clr_sh;
  logic [N_REQ*STAT_BITS-1:0] stat_cnt;
  logic [N_REQ*STAT_BITS-1:0] stat_cnt_sh;
`endif

  dsp_mul_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY), .A_BITS(A_BITS), .B_BITS(B_BITS),
                    .P_BITS(P_BITS), .SHIFT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .bus   (bus)
`ifdef DSP_MUL_ARB_STAT_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  dsp_mul_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY), .A_BITS(A_BITS), .B_BITS(B_BITS),
                    .P_BITS(P_BITS), .SHIFT(4)) dut_sh (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .bus   (bus_sh)
`ifdef DSP_MUL_ARB_STAT_EN
    ,
    .stat_clr (stat_clr_sh),
    .stat_cnt (stat_cnt_sh)
`endif
  );

  int checks = 0;
  int errors = 0;

  int   mdl_ptr = 0;
  logic mdl_v [0:LATENCY];
  exp_t exp_q[$];
  exp_t exp_sh_q[$];

  task automatic checkOutput(input string name, input logic [63:0] expv, input logic [63:0] act);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [P_BITS-1:0] ref_product(input logic signed [A_BITS-1:0] a,
                                                    input logic signed [B_BITS-1:0] b,
                                                    input int sh);
    longint pr;
    pr = longint'(a) * longint'(b);
    pr = pr >>> sh;
    return P_BITS'(pr);
  endfunction

  // One cycle on the main DUT: drive, predict grant and m_valid, then step the model.
  task automatic applyStimulus(input logic [N_REQ-1:0] valid,
                               input logic [N_REQ*A_BITS-1:0] a,
                               input logic [N_REQ*B_BITS-1:0] b,
                               input logic m_rdy, input logic rst, input logic ck);
    logic [N_REQ-1:0]   exp_rdy;
    logic [ID_BITS-1:0] idx;
    logic               adv;
    int                 g;
    exp_t               e;
    @(negedge clk);
    reset       = rst;
    cke         = ck;
    bus.s_valid = valid;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.m_ready = m_rdy;
    #2;
    adv     = ck && !(mdl_v[LATENCY] && !m_rdy);
    exp_rdy = '0;
    g       = -1;
    if (adv && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = ID_BITS'((mdl_ptr + k) % N_REQ);
        if (g < 0 && valid[idx]) g = int'(idx);
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("s_ready", 64'(exp_rdy), 64'(bus.s_ready));
    if (!rst) checkOutput("m_valid", 64'(mdl_v[LATENCY]), 64'(bus.m_valid));
    if (g >= 0) begin
      e.id = ID_BITS'(g);
      e.p  = ref_product(a[g*A_BITS +: A_BITS], b[g*B_BITS +: B_BITS], 0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      mdl_ptr = 0;
      for (int s = 0; s <= LATENCY; s++) mdl_v[s] = 1'b0;
      exp_q.delete();
    end else if (adv) begin
      for (int s = LATENCY; s > 0; s--) mdl_v[s] = mdl_v[s-1];
      mdl_v[0] = (g >= 0);
      if (g >= 0) mdl_ptr = (g + 1) % N_REQ;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  // Single accept on the SHIFT=4 instance from requester 0 with a hand-computed result.
  task automatic applyShift(input int a, input int b, input longint exp_p);
    exp_t e;
    @(negedge clk);
    bus_sh.s_valid            = 4'b0001;
    bus_sh.s_a                = '0;
    bus_sh.s_b                = '0;
    bus_sh.s_a[A_BITS-1:0]    = A_BITS'(a);
    bus_sh.s_b[B_BITS-1:0]    = B_BITS'(b);
    #2;
    checkOutput("sh_s_ready", 64'd1, 64'(bus_sh.s_ready));
    e.id = '0;
    e.p  = P_BITS'(exp_p);
    exp_sh_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus.m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got id %0d p %0h, expected none", bus.m_id, bus.m_p);
        end else begin
          checkOutput("m_id", 64'(exp_q[0].id), 64'(bus.m_id));
          checkOutput("m_p", 64'(exp_q[0].p), 64'(bus.m_p));
          if (bus.m_ready && cke) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus_sh.m_valid) begin
        if (exp_sh_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sh_unexpected_result: got p %0h, expected none", bus_sh.m_p);
        end else begin
          checkOutput("sh_m_id", 64'(exp_sh_q[0].id), 64'(bus_sh.m_id));
          checkOutput("sh_m_p", 64'(exp_sh_q[0].p), 64'(bus_sh.m_p));
          if (bus_sh.m_ready && cke) void'(exp_sh_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N_REQ*A_BITS-1:0] av;
    logic [N_REQ*B_BITS-1:0] bv;
    reset          = 1'b1;
    cke            = 1'b1;
    bus.s_valid    = '0;
    bus.s_a        = '0;
    bus.s_b        = '0;
    bus.m_ready    = 1'b1;
    bus_sh.s_valid = '0;
    bus_sh.s_a     = '0;
    bus_sh.s_b     = '0;
    bus_sh.m_ready = 1'b1;
`ifdef DSP_MUL_ARB_STAT_EN
    stat_clr    = 1'b0;
    stat_clr_sh = 1'b0;
`endif
    for (int s = 0; s <= LATENCY; s++) mdl_v[s] = 1'b0;

    $display("[TB] reset with every requester valid, then grant order");
    for (int i = 0; i < N_REQ; i++) begin
      av[i*A_BITS +: A_BITS] = A_BITS'(i + 1);
      bv[i*B_BITS +: B_BITS] = B_BITS'(10 * (i + 1));
    end
    applyStimulus('1, av, bv, 1'b1, 1'b1, 1'b1);
    applyStimulus('1, av, bv, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) applyStimulus('1, av, bv, 1'b1, 1'b0, 1'b1);
    idle(LATENCY + 2);

    $display("[TB] single requester 2, a=-3 b=7");
    av = '0;
    bv = '0;
    av[2*A_BITS +: A_BITS] = A_BITS'(-3);
    bv[2*B_BITS +: B_BITS] = B_BITS'(7);
    for (int c = 0; c < 6; c++) applyStimulus(4'b0100, av, bv, 1'b1, 1'b0, 1'b1);
    idle(LATENCY + 2);

    $display("[TB] full load, 16 cycles");
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        av[i*A_BITS +: A_BITS] = A_BITS'((i + 1) * 100000 - c * 3331 - 200000);
        bv[i*B_BITS +: B_BITS] = B_BITS'((c + 1) * ((i % 2 == 1) ? -97 : 113) + i);
      end
      applyStimulus('1, av, bv, 1'b1, 1'b0, 1'b1);
    end
    idle(LATENCY + 2);

    $display("[TB] backpressure with a full pipe, then clock-enable hold");
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        av[i*A_BITS +: A_BITS] = A_BITS'(-(c * 50000) + i * 7);
        bv[i*B_BITS +: B_BITS] = B_BITS'(131071 - c * 1000 - i);
      end
      applyStimulus('1, av, bv, 1'b1, 1'b0, 1'b1);
    end
    for (int c = 0; c < 5; c++) applyStimulus('1, av, bv, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) applyStimulus('1, av, bv, 1'b1, 1'b0, 1'b0);
    applyStimulus('1, av, bv, 1'b1, 1'b0, 1'b1);
    idle(LATENCY + 4);

    $display("[TB] largest magnitudes, no shift");
    av = '0;
    bv = '0;
    av[A_BITS-1:0] = A_BITS'(-(1 << 26));
    bv[B_BITS-1:0] = B_BITS'(-(1 << 17));
    av[A_BITS +: A_BITS] = A_BITS'((1 << 26) - 1);
    bv[B_BITS +: B_BITS] = B_BITS'(-(1 << 17));
    applyStimulus(4'b0011, av, bv, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0011, av, bv, 1'b1, 1'b0, 1'b1);
    idle(LATENCY + 2);

    $display("[TB] reset with results in flight");
    av = '0;
    bv = '0;
    av[A_BITS +: A_BITS] = A_BITS'(12345);
    bv[B_BITS +: B_BITS] = B_BITS'(-321);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0010, av, bv, 1'b1, 1'b0, 1'b1);
    idle(1);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(LATENCY + 4);

`ifdef DSP_MUL_ARB_STAT_EN
    $display("[TB] statistics counters");
    for (int i = 0; i < N_REQ; i++) checkOutput("stat_after_reset", 64'd0, 64'(stat_cnt[i*STAT_BITS +: STAT_BITS]));
    applyStimulus(4'b0010, av, bv, 1'b1, 1'b0, 1'b1);
    #3;
    checkOutput("stat_one_accept", 64'd1, 64'(stat_cnt[STAT_BITS +: STAT_BITS]));
    stat_clr = 1'b1;
    applyStimulus(4'b0010, av, bv, 1'b1, 1'b0, 1'b1);
    #3;
    stat_clr = 1'b0;
    checkOutput("stat_clr_with_grant", 64'd0, 64'(stat_cnt[STAT_BITS +: STAT_BITS]));
    idle(LATENCY + 2);
`endif

    $display("[TB] SHIFT=4 instance, arithmetic shift and truncation");
    applyShift(-(1 << 26), (1 << 17) - 1, -64'sd549751619584);
    applyShift(-(1 << 26), -(1 << 17), 64'sd549755813888);
    applyShift((1 << 26) - 1, (1 << 17) - 1, 64'sd549751611392);
    applyShift(-3, 7, -64'sd2);
    @(negedge clk);
    bus_sh.s_valid = '0;
    idle(LATENCY + 4);

    checkOutput("main_queue_drained", 64'd0, 64'(exp_q.size()));
    checkOutput("shift_queue_drained", 64'd0, 64'(exp_sh_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
